// File: rtl/sort_sched_if.sv
// sort_sched_if: requester, engine and completion signals of the shared sort scheduler.
//   req/req_data/gnt          : requester side (frame slice i is req_data[i*W +: W])
//   eng_rst/eng_en/eng_num    : engine control and digit stream
//   eng_valid/eng_out         : engine result
//   done/done_id/result/err   : completion report
// master = scheduler, slave = requesters plus engine.
interface sort_sched_if #(
    parameter int NREQ   = 4,
    parameter int DIGITS = 10
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(NREQ);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              eng_rst;
    logic              eng_en;
    logic [3:0]        eng_num;
    logic              eng_valid;
    logic [W-1:0]      eng_out;
    logic              done;
    logic [IW-1:0]     done_id;
    logic [W-1:0]      result;
    logic              err;
    modport master (
        input  req, req_data, eng_valid, eng_out,
        output gnt, eng_rst, eng_en, eng_num, done, done_id, result, err
    );
    modport slave (
        output req, req_data, eng_valid, eng_out,
        input  gnt, eng_rst, eng_en, eng_num, done, done_id, result, err
    );
endinterface

// File: rtl/sort_sched.sv
// sort_sched: round-robin scheduler sharing one even-sort engine between NREQ requesters.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (also holds the engine clear)
//   sif  : sort_sched_if.master -- requests/grants, engine pins, completion report
// Flow: IDLE (arbitrate, capture frame) -> CLEAR (engine reset) -> LOAD (one digit
// per cycle, MS nibble first) -> WAIT (valid or timeout) -> DONE (report) -> IDLE.
module sort_sched #(
    parameter int NREQ    = 4,
    parameter int DIGITS  = 10,
    parameter int TIMEOUT = 31
) (
    input logic         clk,
    input logic         rst,
    sort_sched_if.master sif
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(DIGITS);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  frame;
    logic [IW-1:0] cur_id, last, pick, idx;
    logic          hit;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [W-1:0]  result_r;
    logic          err_r;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last) + i) % NREQ);
            if (!hit && sif.req[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = hit ? CLEAR : IDLE;
            CLEAR:   state_n = LOAD;
            LOAD:    state_n = (cnt == CW'(DIGITS - 1)) ? WAIT : LOAD;
            WAIT:    state_n = (sif.eng_valid || timer == TW'(TIMEOUT)) ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame    <= '0;
            cur_id   <= '0;
            last     <= IW'(NREQ - 1);
            cnt      <= '0;
            timer    <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (hit) begin
                    frame  <= sif.req_data[int'(pick)*W +: W];
                    cur_id <= pick;
                    last   <= pick;
                end
                CLEAR: cnt <= '0;
                LOAD: begin
                    if (cnt != CW'(DIGITS - 1)) cnt <= cnt + 1'b1;
                    timer <= '0;
                end
                WAIT: begin
                    if (sif.eng_valid) begin
                        result_r <= sif.eng_out;
                        err_r    <= 1'b0;
                    end else if (timer == TW'(TIMEOUT)) begin
                        result_r <= '0;
                        err_r    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is a register or a decode of registered state; reset also
    // holds the engine clear so an aborted job leaves nothing behind.
    assign sif.gnt     = (state == CLEAR) ? (NREQ'(1) << cur_id) : '0;
    assign sif.eng_rst = rst | (state == CLEAR);
    assign sif.eng_en  = (state == LOAD);
    assign sif.eng_num = (state == LOAD) ? frame[W-1-4*int'(cnt) -: 4] : 4'd0;
    assign sif.done    = (state == DONE);
    assign sif.done_id = cur_id;
    assign sif.result  = result_r;
    assign sif.err     = err_r;
endmodule
